led_shift_monitor: RTL
======================

Name: led_shift_monitor

Overview:
- Receive-side checker for the rotating LED bus driven by the LED shifter.
- Samples the 8-bit LED vector in the same clock domain and verifies that each change is a one-position rotation at the expected period.
- Reports lock, direction, shift count, measured interval, and sticky fault codes.
- Used on-chip as a self-test and in benches as a scoreboard for the shifter.

Parameters:
- CLK_FREQ, 25_000_000, clock frequency in Hz.
- EXP_DIV, 4, expected shift period = CLK_FREQ/EXP_DIV cycles (EXP).
- TOL, 2, allowed deviation of an interval from EXP, in cycles.
- LOCK_N, 2, consecutive good intervals required to lock.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- leds_in  in  8  LED vector under test, synchronous to clk
- clr  in  1  single-cycle pulse; clears a fault
- locked  out  1  pattern tracked and in tolerance
- dir  out  1  0 = left rotation {l[6:0],l[7]}; 1 = right rotation {l[0],l[7:1]}
- shift_cnt  out  16  valid shifts counted while locked; wraps
- period  out  32  most recent measured change-to-change interval, in cycles
- err  out  1  sticky fault flag
- err_code  out  2  0 none, 1 bad pattern, 2 timing, 3 stall

Behaviour:
- Reset values: all outputs 0. prev=0, cnt=0, good=0, state=IDLE. rst is sampled only on a clk edge; asserting it mid-operation returns everything to reset values on that edge.
- prev holds leds_in from the previous cycle. A change is detected when leds_in != prev.
- Rotation classification:
  - rotL when leds_in == {prev[6:0],prev[7]}.
  - rotR when leds_in == {prev[0],prev[7:1]}.
  - If both match (e.g. 0x55/0xAA), the change is valid and dir is kept.
- cnt increments every cycle and saturates at 32'hFFFF_FFFF. On a change:
  - interval = cnt+1;
  - period <= interval, but only once timing is established (first change after IDLE/ACQUIRE entry is not captured);
  - cnt <= 0.
- An interval is good when EXP-TOL <= interval <= EXP+TOL.
- Timing: the comparison is combinational against prev. State and outputs register on the same edge, so outputs reflect a leds_in change one clock after it appears.
- FSM:
  - IDLE: one cycle, loads prev, then goes to ACQUIRE.
  - ACQUIRE:
    - The first change only arms timing; it sets good=0 and records dir if valid.
    - Each later change counts as good only if it is a valid rotation in the same dir and the interval is good. Good increments good; anything else sets good=0 and re-arms.
    - When good reaches LOCK_N, go to LOCKED: locked=1, shift_cnt=0.
    - No stall detection in ACQUIRE.
  - LOCKED:
    - On a change that is a valid rotation in dir with a good interval, shift_cnt++.
    - Invalid pattern or wrong direction: go to FAULT with code 1.
    - Interval out of tolerance: go to FAULT with code 2.
    - cnt reaching EXP+TOL+1 with no change: go to FAULT with code 3. This covers constant 0x00 or 0xFF.
    - On entering FAULT, err=1 and locked=0 on the same edge.
    - If pattern and timing both fail, code 1 wins.
  - FAULT:
    - err and err_code hold; cnt and prev keep running.
    - clr moves to ACQUIRE with err=0, err_code=0, good=0.
    - clr has no effect in other states.
- shift_cnt holds its value outside LOCKED.

Optional Feature:
- Macro: LED_MON_BIDIR_EN.
- Defined: both directions are accepted, and dir reports the locked direction.
- Undefined: only rotL is valid, dir is tied to 0, and any rotR in LOCKED gives FAULT code 1.

Decomposition:
- Package led_mon_pkg holds:
  - state enum {IDLE, ACQUIRE, LOCKED, FAULT};
  - err_code constants ERR_NONE/ERR_PATTERN/ERR_TIMING/ERR_STALL;
  - helper functions rotl8/rotr8.
- One natural sub-module: led_interval_timer, covering the saturating cnt, interval capture and the good/stall compares.

Test Plan:
All scenarios use CLK_FREQ=400, EXP_DIV=4 (EXP=100), TOL=2, LOCK_N=2.
- Locking:
  - Stimulus: seed 0x1F, rotate left every 100 cycles.
  - Response: locked=1 one clock after the 3rd change; dir=0, period=100; shift_cnt 1,2,3 on later shifts.
- Bad pattern:
  - Stimulus: while locked at 0x3E, drive 0x3D.
  - Response: next clock err=1, err_code=1, locked=0; shift_cnt frozen.
- Timing:
  - Stimulus: while locked, a 102-cycle interval, then a 97-cycle interval.
  - Response: 102 is accepted with period=102; 97 gives err_code=2.
- Stall and clear:
  - Stimulus: while locked, hold the value.
  - Response: at 103 cycles without a change, err_code=3. Pulse clr: err=0, state ACQUIRE, relock after 3 changes.
- Reset and direction:
  - Stimulus: rst mid-LOCKED.
  - Response: next clock all outputs 0.
  - Stimulus: right-rotation stream 0x80→0x40→…
  - Response with LED_MON_BIDIR_EN: lock with dir=1. Without it: never locks.

Source files
------------

// File: rtl/led_mon_pkg.sv
// led_mon_pkg: shared states, fault codes and rotation helpers for the LED shift monitor
package led_mon_pkg;

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_PATTERN = 2'd1;
   localparam logic [1:0] ERR_TIMING  = 2'd2;
   localparam logic [1:0] ERR_STALL   = 2'd3;

   function automatic logic [7:0] rotl8(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   function automatic logic [7:0] rotr8(input logic [7:0] v);
      return {v[0], v[7:1]};
   endfunction

endpackage

// File: rtl/led_shift_monitor_if.sv
// led_shift_monitor_if: LED bus under test plus the monitor's status outputs
interface led_shift_monitor_if;

   logic [7:0]  leds_in;
   logic        clr;
   logic        locked;
   logic        dir;
   logic [15:0] shift_cnt;
   logic [31:0] period;
   logic        err;
   logic [1:0]  err_code;

   modport master (output leds_in, clr, input locked, dir, shift_cnt, period, err, err_code);
   modport slave  (input leds_in, clr, output locked, dir, shift_cnt, period, err, err_code);

endinterface

// File: rtl/led_interval_timer.sv
// led_interval_timer: saturating cycles-since-change counter with tolerance and stall compares
module led_interval_timer #(
   parameter int unsigned EXP = 100,
   parameter int unsigned TOL = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        change,
   output logic [31:0] interval,
   output logic        good,
   output logic        stall
);

   localparam logic [31:0] LO = EXP - TOL;
   localparam logic [31:0] HI = EXP + TOL;

   logic [31:0] cnt_q, cnt_d;

   // interval is the change-to-change distance if a change lands this cycle; a change restarts the count
   always_comb begin
      interval = &cnt_q ? cnt_q : cnt_q + 32'd1;
      cnt_d    = change ? '0 : interval;
      good     = interval >= LO && interval <= HI;
      stall    = !change && interval > HI;
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_shift_monitor.sv
// led_shift_monitor: verifies the LED bus rotates one position per expected period; LED_MON_BIDIR_EN also accepts right rotation
module led_shift_monitor
   import led_mon_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 25_000_000,
   parameter int unsigned EXP_DIV  = 4,
   parameter int unsigned TOL      = 2,
   parameter int unsigned LOCK_N   = 2
) (
   input logic clk,
   input logic rst,
   led_shift_monitor_if.slave bus
);

   localparam int unsigned EXP = CLK_FREQ / EXP_DIV;

   state_t      state_q, state_d;
   logic [7:0]  prev_q, prev_d;
   logic [7:0]  good_q, good_d;
   logic        armed_q, armed_d;
   logic        dir_q, dir_d;
   logic [15:0] shift_q, shift_d;
   logic [31:0] period_q, period_d;
   logic [1:0]  code_q, code_d;
   logic        change, is_l, is_r, valid, new_dir, dir_ok, int_good, stall;
   logic [31:0] interval;

   assign change = bus.leds_in != prev_q;
   assign is_l   = bus.leds_in == rotl8(prev_q);
   assign is_r   = bus.leds_in == rotr8(prev_q);
   assign dir_ok = dir_q ? is_r : is_l;

`ifdef LED_MON_BIDIR_EN
   assign valid   = is_l | is_r;
   assign new_dir = (is_l & is_r) ? dir_q : is_r;
`else
   assign valid   = is_l;
   assign new_dir = 1'b0;
`endif

   led_interval_timer #(.EXP(EXP), .TOL(TOL)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .change   (change),
      .interval (interval),
      .good     (int_good),
      .stall    (stall)
   );

   // acquire/lock/fault sequencing; a pattern fault outranks a timing fault on the same change
   always_comb begin
      state_d  = state_q;
      prev_d   = bus.leds_in;
      good_d   = good_q;
      armed_d  = armed_q;
      dir_d    = dir_q;
      shift_d  = shift_q;
      period_d = (change && armed_q && (state_q == ACQUIRE || state_q == LOCKED)) ? interval : period_q;
      code_d   = code_q;
      case (state_q)
         IDLE: begin
            state_d = ACQUIRE;
            armed_d = 1'b0;
            good_d  = '0;
         end
         ACQUIRE: if (change) begin
            armed_d = 1'b1;
            if (armed_q && dir_ok && int_good) begin
               good_d = good_q + 8'd1;
               if (good_d == 8'(LOCK_N)) begin
                  state_d = LOCKED;
                  shift_d = '0;
               end
            end else begin
               good_d = '0;
               dir_d  = valid ? new_dir : dir_q;
            end
         end
         LOCKED: begin
            if (change && !dir_ok) begin
               state_d = FAULT;
               code_d  = ERR_PATTERN;
            end else if (change && !int_good) begin
               state_d = FAULT;
               code_d  = ERR_TIMING;
            end else if (change) begin
               shift_d = shift_q + 16'd1;
            end else if (stall) begin
               state_d = FAULT;
               code_d  = ERR_STALL;
            end
         end
         FAULT: if (bus.clr) begin
            state_d = ACQUIRE;
            code_d  = ERR_NONE;
            good_d  = '0;
            armed_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         prev_q   <= '0;
         good_q   <= '0;
         armed_q  <= 1'b0;
         dir_q    <= 1'b0;
         shift_q  <= '0;
         period_q <= '0;
         code_q   <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         good_q   <= good_d;
         armed_q  <= armed_d;
         dir_q    <= dir_d;
         shift_q  <= shift_d;
         period_q <= period_d;
         code_q   <= code_d;
      end
   end

   assign bus.locked    = state_q == LOCKED;
   assign bus.err       = state_q == FAULT;
   assign bus.dir       = dir_q;
   assign bus.shift_cnt = shift_q;
   assign bus.period    = period_q;
   assign bus.err_code  = code_q;

endmodule
